// File: rtl/fir3p_pkg.sv
// Shared constants and encodings for the 3-parallel FIR input sequencer.
// Imported by the coefficient bank, the interface users and the sequencer top.
package fir3p_pkg;

   localparam int NBIT_DEF = 10;
   localparam int NTAP     = 11;
   localparam int ADDR_W   = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SWAP  = 2'd2
   } fsm_state_e;

   typedef enum logic [1:0] {
      LANE0 = 2'd0,
      LANE1 = 2'd1,
      LANE2 = 2'd2
   } lane_e;

endpackage

// File: rtl/fir3p_if.sv
// Sample stream, coefficient config port and parallel filter-side outputs of fir3p_sequencer.
// Handshake: a sample transfers on a rising CLK edge where S_VALID && S_READY; S_READY never depends on S_VALID.
interface fir3p_if #(
   parameter int NBIT = 10
);
   logic            S_VALID;
   logic [NBIT-1:0] S_DATA;
   logic            S_READY;

   logic            CFG_WE;
   logic [3:0]      CFG_ADDR;
   logic [NBIT-1:0] CFG_DATA;
   logic            CFG_COMMIT;
   logic            CFG_BUSY;

   logic [NBIT-1:0] Din3k;
   logic [NBIT-1:0] Din3k1;
   logic [NBIT-1:0] Din3k2;
   logic            Vin;

   logic [NBIT-1:0] B0, B1, B2, B3, B4, B5, B6, B7, B8, B9, B10;

   modport master (
      output S_VALID, S_DATA, CFG_WE, CFG_ADDR, CFG_DATA, CFG_COMMIT,
      input  S_READY, CFG_BUSY, Din3k, Din3k1, Din3k2, Vin,
      input  B0, B1, B2, B3, B4, B5, B6, B7, B8, B9, B10
   );

   modport slave (
      input  S_VALID, S_DATA, CFG_WE, CFG_ADDR, CFG_DATA, CFG_COMMIT,
      output S_READY, CFG_BUSY, Din3k, Din3k1, Din3k2, Vin,
      output B0, B1, B2, B3, B4, B5, B6, B7, B8, B9, B10
   );
endinterface

// File: rtl/fir3p_coef_bank.sv
// Shadow/active coefficient register pair: shadow is written over the config port,
// active drives the filter taps and is reloaded from shadow only on the swap strobe.
module fir3p_coef_bank
   import fir3p_pkg::*;
#(
   parameter int NBIT = NBIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [NBIT-1:0]   wdata,
   input  logic              swap,
   output logic [NBIT-1:0]   coef [NTAP]
);

   logic [NBIT-1:0] shadow_q [NTAP];
   logic [NBIT-1:0] shadow_d [NTAP];
   logic [NBIT-1:0] active_q [NTAP];
   logic [NBIT-1:0] active_d [NTAP];

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      // Addresses beyond the last tap are silently dropped.
      if (we && (addr < ADDR_W'(NTAP))) begin
         shadow_d[addr] = wdata;
      end
      if (swap) begin
         active_d = shadow_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '{default: '0};
         active_q <= '{default: '0};
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign coef = active_q;

endmodule

// File: rtl/fir3p_sequencer.sv
// Packs a serial sample stream into 3-sample parallel words for myfilter and swaps
// coefficient banks only after the filter pipeline has been drained.
module fir3p_sequencer
   import fir3p_pkg::*;
#(
   parameter int NBIT      = NBIT_DEF,
   parameter int DRAIN_CYC = 4
) (
   input  logic       CLK,
   input  logic       RST_n,
   fir3p_if.slave     bus,
   output fsm_state_e dbg_state
);

   localparam int CNT_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

   fsm_state_e      state_q, state_d;
   lane_e           lane_q, lane_d;
   logic [NBIT-1:0] hold0_q, hold0_d;
   logic [NBIT-1:0] hold1_q, hold1_d;
   logic [NBIT-1:0] din0_q, din0_d;
   logic [NBIT-1:0] din1_q, din1_d;
   logic [NBIT-1:0] din2_q, din2_d;
   logic            vin_q, vin_d;
   logic            pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic            s_ready;
   logic            accept;
   logic            swap;
   logic [NBIT-1:0] coef [NTAP];

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      hold0_d = hold0_q;
      hold1_d = hold1_q;
      din0_d  = din0_q;
      din1_d  = din1_q;
      din2_d  = din2_q;
      vin_d   = 1'b0;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      s_ready = 1'b0;
      swap    = 1'b0;
      accept  = 1'b0;

      case (state_q)
         RUN: begin
            // An open group is allowed to complete before the drain begins.
            s_ready = !(pend_q && (lane_q == LANE0));
            if (pend_q && (lane_q == LANE0)) begin
               state_d = DRAIN;
               cnt_d   = CNT_W'(DRAIN_CYC - 1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = SWAP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         SWAP: begin
            swap    = 1'b1;
            pend_d  = 1'b0;
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      accept = bus.S_VALID && s_ready && RST_n;
      if (accept) begin
         case (lane_q)
            LANE0: begin
               hold0_d = bus.S_DATA;
               lane_d  = LANE1;
            end
            LANE1: begin
               hold1_d = bus.S_DATA;
               lane_d  = LANE2;
            end
            default: begin
               din0_d = hold0_q;
               din1_d = hold1_q;
               din2_d = bus.S_DATA;
               vin_d  = 1'b1;
               lane_d = LANE0;
            end
         endcase
      end

      if (bus.CFG_COMMIT && !pend_q) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= RUN;
         lane_q  <= LANE0;
         hold0_q <= '0;
         hold1_q <= '0;
         din0_q  <= '0;
         din1_q  <= '0;
         din2_q  <= '0;
         vin_q   <= 1'b0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         hold0_q <= hold0_d;
         hold1_q <= hold1_d;
         din0_q  <= din0_d;
         din1_q  <= din1_d;
         din2_q  <= din2_d;
         vin_q   <= vin_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
      end
   end

   // Config writes are frozen for the whole commit so the swapped bank is well defined.
   fir3p_coef_bank #(
      .NBIT (NBIT)
   ) u_coef_bank (
      .clk   (CLK),
      .rst_n (RST_n),
      .we    (bus.CFG_WE && !pend_q),
      .addr  (bus.CFG_ADDR),
      .wdata (bus.CFG_DATA),
      .swap  (swap),
      .coef  (coef)
   );

   assign bus.S_READY  = s_ready && RST_n;
   assign bus.CFG_BUSY = pend_q;
   assign bus.Din3k    = din0_q;
   assign bus.Din3k1   = din1_q;
   assign bus.Din3k2   = din2_q;
   assign bus.Vin      = vin_q;
   assign bus.B0       = coef[0];
   assign bus.B1       = coef[1];
   assign bus.B2       = coef[2];
   assign bus.B3       = coef[3];
   assign bus.B4       = coef[4];
   assign bus.B5       = coef[5];
   assign bus.B6       = coef[6];
   assign bus.B7       = coef[7];
   assign bus.B8       = coef[8];
   assign bus.B9       = coef[9];
   assign bus.B10      = coef[10];
   assign dbg_state    = state_q;

endmodule
